// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - state encoding, default parameters and counter sizing for reset_sequencer
package reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        RELEASE    = 3'd1,
        WAIT_READY = 3'd2,
        DONE       = 3'd3,
        HOLD       = 3'd4
    } seq_state_t;

    localparam int DEF_NUM_STAGES     = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_LOCK_FILTER    = 8;
    localparam int DEF_STAGE_DELAY    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // A counter only ever compared against limit-1 needs clog2(limit) bits, minimum one.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - parameterized-depth flop chain synchronizer with asynchronous active-high clear
module sync_ff #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [DEPTH];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged release of per-subsystem active-low resets after PLL lock
// Optional ready-wait timeout with sticky seq_error: define RESET_SEQ_TIMEOUT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES     = DEF_NUM_STAGES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int LOCK_FILTER    = DEF_LOCK_FILTER,
    parameter int STAGE_DELAY    = DEF_STAGE_DELAY,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  sys_reset,
    input  logic                  locked_in,
    input  logic                  soft_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  seq_done,
    output logic                  seq_error
);

    localparam int LOCK_W = cnt_width(LOCK_FILTER);
    localparam int DLY_W  = cnt_width(STAGE_DELAY);
    localparam int IDX_W  = cnt_width(NUM_STAGES);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || SYNC_STAGES < 2 || LOCK_FILTER < 1 ||
        STAGE_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("reset_sequencer: parameter out of range");
    end

    seq_state_t            state_q, state_d;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [DLY_W-1:0]      dly_cnt_q, dly_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
    logic                  done_q, done_d;
    logic                  locked_s, abort, ready_hit, ready_go;

    sync_ff #(.DEPTH(SYNC_STAGES), .WIDTH(1)) u_lock_sync (
        .clk (clk),
        .clr (sys_reset),
        .d   (locked_in),
        .q   (locked_s)
    );

    assign ready_hit = stage_ready[idx_q];
    assign abort     = (state_q inside {RELEASE, WAIT_READY, DONE}) && (!locked_s || soft_reset_req);

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q    <= WAIT_LOCK;
            lock_cnt_q <= '0;
            dly_cnt_q  <= '0;
            idx_q      <= '0;
            rst_n_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            idx_q      <= idx_d;
            rst_n_q    <= rst_n_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        idx_d      = idx_q;
        rst_n_d    = rst_n_q;
        done_d     = done_q;
        case (state_q)
            WAIT_LOCK: begin
                if (!locked_s) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d    = RELEASE;
                    lock_cnt_d = '0;
                    dly_cnt_d  = '0;
                    idx_d      = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (dly_cnt_q == DLY_LAST) begin
                    state_d          = WAIT_READY;
                    dly_cnt_d        = '0;
                    rst_n_d[idx_q]   = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            WAIT_READY: begin
                if (ready_go) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = RELEASE;
                        idx_d     = idx_q + 1'b1;
                        dly_cnt_d = '0;
                    end
                end
            end
            DONE: begin
            end
            HOLD: begin
                if (dly_cnt_q == DLY_LAST) begin
                    state_d    = WAIT_LOCK;
                    dly_cnt_d  = '0;
                    lock_cnt_d = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
                dly_cnt_d  = '0;
                idx_d      = '0;
                rst_n_d    = '0;
                done_d     = 1'b0;
            end
        endcase
        // Abort overrides whatever the state decided, including a release on this edge.
        if (abort) begin
            state_d    = HOLD;
            lock_cnt_d = '0;
            dly_cnt_d  = '0;
            idx_d      = '0;
            rst_n_d    = '0;
            done_d     = 1'b0;
        end
    end

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam int WAIT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    assign ready_go = ready_hit || (wait_cnt_q == WAIT_LAST);

    always_comb begin
        wait_cnt_d = '0;
        err_d      = err_q;
        if (state_q == WAIT_READY && state_d == WAIT_READY) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (state_q == WAIT_READY && !abort && !ready_hit && wait_cnt_q == WAIT_LAST) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign seq_error = err_q;
`else
    assign ready_go  = ready_hit;
    assign seq_error = 1'b0;
`endif

    assign rst_n_out = rst_n_q;
    assign seq_done  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer (vector table, corner sequences, random vs model)
`timescale 1ns/1ps
module tb_reset_sequencer;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int LF   = 8;
    localparam int SD   = 16;
    localparam int TO   = 10;
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         sys_reset = 1'b1;
    logic         locked_in = 1'b0;
    logic         soft_reset_req = 1'b0;
    logic [N-1:0] stage_ready = '0;
    logic [N-1:0] rst_n_out;
    logic         seq_done;
    logic         seq_error;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    bit chk_model = 1'b0;
    int lock_low = 0;

    // Reference model: lock history queue plus counts of released stages and elapsed cycles.
    int m_lkq[$];
    int m_run, m_hold, m_rel, m_delay, m_tmo;
    bit m_active, m_wait, m_done, m_err;

    typedef struct {
        int         cyc;
        logic       lock;
        logic [3:0] ready;
        logic [3:0] rst;
        logic       done;
    } vec_t;
    vec_t nom [10];

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES     (N),
        .SYNC_STAGES    (SYNC),
        .LOCK_FILTER    (LF),
        .STAGE_DELAY    (SD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .sys_reset      (sys_reset),
        .locked_in      (locked_in),
        .soft_reset_req (soft_reset_req),
        .stage_ready    (stage_ready),
        .rst_n_out      (rst_n_out),
        .seq_done       (seq_done),
        .seq_error      (seq_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_out();
        return 32'({seq_error, seq_done, rst_n_out});
    endfunction

    function automatic logic [31:0] model_exp();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < m_rel; i++) r[i] = 1'b1;
        return 32'({m_err, m_done, r});
    endfunction

    task automatic model_reset();
        m_lkq.delete();
        for (int i = 0; i < SYNC; i++) m_lkq.push_back(0);
        m_run = 0; m_hold = 0; m_rel = 0; m_delay = 0; m_tmo = 0;
        m_active = 0; m_wait = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        int ls;
        bit ok;
        ls = m_lkq.pop_front();
        m_lkq.push_back(locked_in ? 1 : 0);
        if (m_hold > 0) begin
            m_hold--;
        end else if (!m_active) begin
            m_run = (ls == 1) ? m_run + 1 : 0;
            if (m_run == LF) begin
                m_active = 1; m_run = 0; m_rel = 0; m_delay = 0; m_wait = 0;
            end
        end else if (ls == 0 || soft_reset_req) begin
            m_active = 0; m_hold = SD; m_rel = 0; m_delay = 0;
            m_wait = 0; m_done = 0; m_tmo = 0; m_run = 0;
        end else if (m_done) begin
            m_done = 1;
        end else if (!m_wait) begin
            m_delay++;
            if (m_delay == SD) begin
                m_rel++; m_wait = 1; m_tmo = 0;
            end
        end else begin
            ok = stage_ready[m_rel-1];
            m_tmo++;
            if (ok || (TMO_EN && m_tmo == TO)) begin
                if (!ok) m_err = 1;
                m_wait = 0; m_delay = 0;
                if (m_rel == N) m_done = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        edge_n++;
        #1;
        if (chk_model) check($sformatf("model@%0d", edge_n), dut_out(), model_exp());
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic expect_at(input string name, input int e, input logic [3:0] rst,
                             input logic done, input logic err);
        run_to(e);
        check($sformatf("%s@%0d", name, e), dut_out(), 32'({err, done, rst}));
    endtask

    task automatic do_reset();
        sys_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_out(), 32'd0);
        model_reset();
        sys_reset = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int viol;
        model_reset();

        nom[0] = '{25, 1'b1, 4'hF, 4'h0, 1'b0};
        nom[1] = '{26, 1'b1, 4'hF, 4'h1, 1'b0};
        nom[2] = '{42, 1'b1, 4'hF, 4'h1, 1'b0};
        nom[3] = '{43, 1'b1, 4'hF, 4'h3, 1'b0};
        nom[4] = '{59, 1'b1, 4'hF, 4'h3, 1'b0};
        nom[5] = '{60, 1'b1, 4'hF, 4'h7, 1'b0};
        nom[6] = '{76, 1'b1, 4'hF, 4'h7, 1'b0};
        nom[7] = '{77, 1'b1, 4'hF, 4'hF, 1'b0};
        nom[8] = '{78, 1'b1, 4'hF, 4'hF, 1'b1};
        nom[9] = '{90, 1'b1, 4'hF, 4'hF, 1'b1};

        // Nominal sequence
        locked_in = 1'b1;
        stage_ready = 4'hF;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            locked_in = nom[i].lock;
            stage_ready = nom[i].ready;
            run_to(nom[i].cyc);
            check($sformatf("nominal@%0d", nom[i].cyc), dut_out(),
                  32'({1'b0, nom[i].done, nom[i].rst}));
        end

        // Soft reset in DONE, with a second request during HOLD that must be ignored
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        a = edge_n;
        check("abort_done", dut_out(), 32'd0);
        run_to(a + 4);
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        check("hold_ignores_soft", dut_out(), 32'd0);
        expect_at("rerun_s0_low", a + 39, 4'h0, 1'b0, 1'b0);
        expect_at("rerun_s0_high", a + 40, 4'h1, 1'b0, 1'b0);
        expect_at("rerun_pre_done", a + 91, 4'hF, 1'b0, 1'b0);
        expect_at("rerun_done", a + 92, 4'hF, 1'b1, 1'b0);

        // Lock glitch restarts the filter
        locked_in = 1'b1;
        stage_ready = 4'hF;
        do_reset();
        run_to(5);
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        expect_at("glitch_no_early", 26, 4'h0, 1'b0, 1'b0);
        expect_at("glitch_pre", 31, 4'h0, 1'b0, 1'b0);
        expect_at("glitch_rise", 32, 4'h1, 1'b0, 1'b0);

        // Lock loss on the edge that would release stage 2, with ready high
        locked_in = 1'b1;
        stage_ready = 4'hF;
        do_reset();
        run_to(57);
        locked_in = 1'b0;
        expect_at("lockloss_pre", 59, 4'h3, 1'b0, 1'b0);
        expect_at("lockloss_abort", 60, 4'h0, 1'b0, 1'b0);
        expect_at("lockloss_after", 61, 4'h0, 1'b0, 1'b0);
        locked_in = 1'b1;

`ifndef RESET_SEQ_TIMEOUT_EN
        // Stage 1 ready withheld for 100 cycles
        stage_ready = 4'b1101;
        do_reset();
        expect_at("stall_s1", 43, 4'h3, 1'b0, 1'b0);
        viol = 0;
        while (edge_n < 143) begin
            tick();
            if (rst_n_out[2]) viol++;
        end
        check("stall_bit2_low", 32'(viol), 32'd0);
        check("stall_held@143", dut_out(), 32'h3);
        stage_ready = 4'hF;
        expect_at("stall_pre", 159, 4'h3, 1'b0, 1'b0);
        expect_at("stall_release", 160, 4'h7, 1'b0, 1'b0);
`else
        // Ready never arrives: every stage advances on timeout
        stage_ready = 4'h0;
        do_reset();
        expect_at("tmo_pre", 35, 4'h1, 1'b0, 1'b0);
        expect_at("tmo_first", 36, 4'h1, 1'b0, 1'b1);
        expect_at("tmo_s1", 52, 4'h3, 1'b0, 1'b1);
        expect_at("tmo_s2", 78, 4'h7, 1'b0, 1'b1);
        expect_at("tmo_s3", 104, 4'hF, 1'b0, 1'b1);
        expect_at("tmo_pre_done", 113, 4'hF, 1'b0, 1'b1);
        expect_at("tmo_done", 114, 4'hF, 1'b1, 1'b1);
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        check("tmo_err_sticky", dut_out(), 32'h20);
        expect_at("tmo_rerun_s0", 155, 4'h1, 1'b0, 1'b1);
        #2;
        sys_reset = 1'b1;
        #1;
        check("tmo_async_reset", dut_out(), 32'd0);
`endif

        // Randomized traffic against the model
        locked_in = 1'b1;
        stage_ready = 4'hF;
        do_reset();
        chk_model = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            if (lock_low > 0) begin
                lock_low--;
                locked_in = 1'b0;
            end else begin
                locked_in = 1'b1;
                if ($urandom_range(0, 399) == 0) lock_low = $urandom_range(1, 4);
            end
            soft_reset_req = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) begin
                for (int b = 0; b < N; b++) stage_ready[b] = ($urandom_range(0, 7) != 0);
            end
            tick();
        end
        chk_model = 1'b0;
        soft_reset_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumer-side counterpart to the clock/reset generator. It takes the raw PLL lock indication and a system reset, and releases per-subsystem active-low resets one stage at a time.
- Each stage is released only after the previous stage has acknowledged ready.
- Sits directly after the PLL, in the core clock domain. Drives rst_n of CPU, memories, peripherals and the EIM bridge in a fixed order.
- Re-runs the whole sequence on loss of lock or on a software reset request.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs (1..8).
- SYNC_STAGES, 2, synchronizer depth for locked_in (>=2).
- LOCK_FILTER, 8, consecutive synchronized-lock cycles required before sequencing starts (>=1).
- STAGE_DELAY, 16, cycles between entering a stage and releasing its reset; also the HOLD duration (>=1).
- TIMEOUT_CYCLES, 255, ready-wait limit; used only with RESET_SEQ_TIMEOUT_EN (>=1).

Ports:
- clk  in  1  core clock.
- sys_reset  in  1  asynchronous active-high reset.
- locked_in  in  1  PLL lock, asynchronous to clk.
- soft_reset_req  in  1  synchronous single-cycle request to re-sequence.
- stage_ready  in  NUM_STAGES  per-stage ready acknowledge, synchronous, level.
- rst_n_out  out  NUM_STAGES  per-stage active-low reset.
- seq_done  out  1  high while all stages are released.
- seq_error  out  1  sticky ready-timeout flag.

Behaviour:
- Reset is asynchronous and active-high on sys_reset with a single clock, clk. Assertion is immediate; deassertion is acted on at the next clk edge.
- Reset values:
  - rst_n_out = all 0, seq_done = 0, seq_error = 0.
  - state = WAIT_LOCK; all counters 0; stage index 0; synchronizer flops 0.
- locked_s is locked_in passed through SYNC_STAGES flops.
- Lock counter:
  - Increments while locked_s = 1 and clears on locked_s = 0.
  - Active only in WAIT_LOCK; cleared on entry to WAIT_LOCK.
- WAIT_LOCK: when locked_s = 1 and lock counter = LOCK_FILTER-1, go to RELEASE with index 0 and delay counter 0. soft_reset_req is ignored in this state.
- RELEASE: the delay counter increments each cycle. When counter = STAGE_DELAY-1, set rst_n_out[index] <= 1 and go to WAIT_READY.
- WAIT_READY:
  - When stage_ready[index] = 1 and index = NUM_STAGES-1, go to DONE and set seq_done <= 1.
  - When stage_ready[index] = 1 otherwise, index++, delay counter <= 0, go to RELEASE.
  - stage_ready bits for other indices are ignored.
- DONE: holds all outputs.
- Abort:
  - Trigger: in RELEASE, WAIT_READY or DONE, locked_s = 0 or soft_reset_req = 1 goes to HOLD.
  - On the same edge: rst_n_out <= all 0, seq_done <= 0, counters <= 0, index <= 0.
  - Loss of lock takes priority over every other transition in that cycle.
- HOLD: lasts exactly STAGE_DELAY cycles with all outputs low, then goes to WAIT_LOCK. locked_s and soft_reset_req are ignored during HOLD.
- Ordering: rst_n_out bits deassert strictly in ascending index order, never more than one per edge, and all reassert on the same edge.
- Timing:
  - Lock window: locked_in high from reset release and held, with SYNC_STAGES=2.
  - rst_n_out[0] rises SYNC_STAGES+LOCK_FILTER+STAGE_DELAY edges after the first edge that samples locked_in high.
  - Each later stage rises STAGE_DELAY+1 edges after the previous stage, provided ready is already high.
  - seq_done rises 1 edge after the last stage.
- Counters are sized clog2 of their limit. Counters never wrap: they are only compared for equality against their limit and are cleared on every state transition.

Optional Feature:
- Macro: RESET_SEQ_TIMEOUT_EN.
- When defined:
  - A ready-wait counter runs in WAIT_READY.
  - If it reaches TIMEOUT_CYCLES-1 without stage_ready[index], set seq_error <= 1 and proceed exactly as if ready had been asserted.
  - seq_error is cleared only by sys_reset.
- When undefined: WAIT_READY waits indefinitely, seq_error is tied to 0, and there is no counter logic.

Decomposition:
- Shared package/include reset_seq_pkg holds:
  - State encoding constants: WAIT_LOCK=0, RELEASE=1, WAIT_READY=2, DONE=3, HOLD=4, in a 3-bit state field.
  - Default parameter constants.
- One sub-module: sync_ff.
  - Parameterized-depth flop chain, asynchronous active-high clear.
  - Used for locked_in and reusable elsewhere.

Test Plan:
- Nominal sequence (defaults, locked_in high after reset, stage_ready = 4'hF): rst_n_out[0..3] rise at edges 26/43/60/77, seq_done rises at 78, seq_error = 0.
- Lock glitch: locked_in high 5 cycles, low 1, then high → the lock filter restarts, and rst_n_out[0] rises 26 edges after the second rise.
- Ready stall: stage_ready[1] = 0 for 100 cycles then 1 → rst_n_out[2] stays 0 throughout; stage 2 rises STAGE_DELAY+1 edges after ready.
- Abort in DONE: soft_reset_req pulse → next edge rst_n_out = 0 and seq_done = 0; HOLD lasts 16 cycles; sequence repeats with identical timing.
- Lock loss during RELEASE of stage 2, plus simultaneous stage_ready → lock loss wins; all outputs 0 on the same edge.
- Timeout (macro on, TIMEOUT_CYCLES=10, stage_ready = 0): each stage advances after 10 cycles; seq_error = 1 sticky; seq_done still rises. Mid-sequence sys_reset pulse → all outputs 0 asynchronously and seq_error cleared.
